// File: rtl/wb_trace_fifo_if.sv
// Trace capture and readout signal bundle for the writeback trace buffer.
// The slave side is the FIFO itself. The master side is the core-capture
// logic plus the debug readout logic.
interface wb_trace_fifo_if #(
  parameter int AW = 3,
  parameter int DW = 32
);
  // capture side
  logic          trace_en;
  logic          cap_valid;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] res_in;
  // readout side
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_res;
  // status / control
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr_ovf;

  modport slave (
    input  trace_en, cap_valid, pc_in, res_in, out_ready, clr_ovf,
    output out_valid, out_pc, out_res, count, full, overflow, drop_cnt
  );

  modport master (
    output trace_en, cap_valid, pc_in, res_in, out_ready, clr_ovf,
    input  out_valid, out_pc, out_res, count, full, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Writeback trace buffer: queues {pc, result} records from the core and drains them to debug readout.
// Latency: a record pushed in cycle N is presented (first-word-fall-through) in cycle N+1.
// Backpressure: none toward the core; records arriving while full without a pop are dropped and counted.
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  wb_trace_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count_q;
  logic            overflow_q;
  logic [7:0]      drop_q;

  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  // Handshake decode: a full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    push_req = bus.trace_en & bus.cap_valid;
    pop      = (count_q != '0) & bus.out_ready;
    push_ok  = push_req & ((count_q != FULL_CNT) | pop);
    drop     = push_req & ~push_ok;
  end

  // Record storage; left unreset because outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {bus.pc_in, bus.res_in};
    end
  end

  // Pointers wrap naturally; occupancy lives in its own counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (bus.clr_ovf)          drop_q <= 8'd1;
      else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = bus.out_valid ? mem[rd_ptr][2*DW-1:DW] : '0;
  assign bus.out_res   = bus.out_valid ? mem[rd_ptr][DW-1:0]    : '0;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == FULL_CNT);
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: per-scenario tasks with inline checks,
// plus a record scoreboard that predicts accepted pushes and checks every pop.
module tb_wb_trace_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_trace_fifo_if #(.AW(3), .DW(32)) bus ();

  wb_trace_fifo #(.DEPTH(8), .AW(3), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard model
  logic [63:0] q[$];
  int          mcnt = 0;

  always @(posedge rst) begin
    q.delete();
    mcnt = 0;
  end

  always @(negedge clk) begin
    logic        m_pop;
    logic        m_push;
    logic [63:0] rec;
    if (!rst) begin
      checks++;
      if (bus.count !== 4'(mcnt)) begin
        errors++;
        $display("FAIL sb_count: got %0d expected %0d at %0t", bus.count, mcnt, $time);
      end
      checks++;
      if (bus.out_valid !== (mcnt != 0)) begin
        errors++;
        $display("FAIL sb_out_valid: got %b expected %b at %0t", bus.out_valid, (mcnt != 0), $time);
      end
      m_pop  = (mcnt != 0) && (bus.out_ready === 1'b1);
      m_push = (bus.trace_en === 1'b1) && (bus.cap_valid === 1'b1);
      if (m_pop) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop_empty: got pop of %h with no expected record", {bus.out_pc, bus.out_res});
        end else begin
          rec = q.pop_front();
          if ({bus.out_pc, bus.out_res} !== rec) begin
            errors++;
            $display("FAIL sb_record: got %h expected %h at %0t", {bus.out_pc, bus.out_res}, rec, $time);
          end
        end
        mcnt--;
      end
      if (m_push && (mcnt < 8 || m_pop)) begin
        q.push_back({bus.pc_in, bus.res_in});
        mcnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] res);
    bus.cap_valid = 1'b1;
    bus.pc_in     = pc;
    bus.res_in    = res;
    step();
    bus.cap_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle: got valid=%b count=%0d expected valid=0 count=0", bus.out_valid, bus.count);
      end
      checks++;
      if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0 || bus.full !== 1'b0) begin
        errors++;
        $display("FAIL reset_status: got ovf=%b drop=%0d full=%b expected 0/0/0", bus.overflow, bus.drop_cnt, bus.full);
      end
      checks++;
      if (bus.out_pc !== 32'd0 || bus.out_res !== 32'd0) begin
        errors++;
        $display("FAIL reset_data: got pc=%h res=%h expected 0/0", bus.out_pc, bus.out_res);
      end
    end
  endtask

  task automatic test_order();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    bus.trace_en  = 1'b1;
    bus.out_ready = 1'b0;
    push(32'h00, 32'h11);
    push(32'h04, 32'h22);
    push(32'h08, 32'h33);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.count !== 4'(3 - i) || bus.out_pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL order_head%0d: got count=%0d pc=%h expected count=%0d pc=%h", i, bus.count, bus.out_pc, 3 - i, exp_pc[i]);
      end
      step();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_drained: got count=%0d valid=%b expected 0/0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'h200 + 32'(4 * i), 32'(i));
    checks++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: got count=%0d full=%b expected 8/1", bus.count, bus.full);
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ovf_flag: got ovf=%b drop=%0d expected 1/2", bus.overflow, bus.drop_cnt);
    end
    checks++;
    if (bus.out_pc !== 32'h200 || bus.out_res !== 32'd0) begin
      errors++;
      $display("FAIL ovf_head: got pc=%h res=%h expected 200/0", bus.out_pc, bus.out_res);
    end
    bus.out_ready = 1'b1;
    repeat (8) step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h400 + 32'(4 * i), 32'hA0 + 32'(i));
    checks++;
    if (bus.count !== 4'd8 || bus.drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ovf_refill: got count=%0d drop=%0d expected 8/2", bus.count, bus.drop_cnt);
    end
    bus.out_ready = 1'b1;
    repeat (8) step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain: got count=%0d full=%b expected 0/0", bus.count, bus.full);
    end
  endtask

  task automatic test_full_push_pop();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(4 * i), 32'hB0 + 32'(i));
    bus.out_ready = 1'b1;
    push(32'h100, 32'hABC);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.drop_cnt !== 8'd2 || bus.out_pc !== 32'h304) begin
      errors++;
      $display("FAIL fpp_state: got count=%0d drop=%0d pc=%h expected 8/2/304", bus.count, bus.drop_cnt, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    repeat (7) step();
    checks++;
    if (bus.count !== 4'd1 || bus.out_pc !== 32'h100 || bus.out_res !== 32'hABC) begin
      errors++;
      $display("FAIL fpp_last: got count=%0d pc=%h res=%h expected 1/100/abc", bus.count, bus.out_pc, bus.out_res);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    bus.out_ready = 1'b1;
    push(32'h500, 32'h55);
    checks++;
    if (bus.count !== 4'd1 || bus.out_pc !== 32'h500) begin
      errors++;
      $display("FAIL empty_pp: got count=%0d pc=%h expected 1/500", bus.count, bus.out_pc);
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_trace_en();
    push(32'h600, 32'h1);
    push(32'h604, 32'h2);
    bus.trace_en  = 1'b0;
    bus.cap_valid = 1'b1;
    bus.pc_in     = 32'hDEAD;
    repeat (3) step();
    bus.cap_valid = 1'b0;
    checks++;
    if (bus.count !== 4'd2) begin
      errors++;
      $display("FAIL trace_en_off: got count=%0d expected 2", bus.count);
    end
    bus.out_ready = 1'b1;
    repeat (2) step();
    bus.out_ready = 1'b0;
    bus.trace_en  = 1'b1;
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h700 + 32'(4 * i), 32'(i));
    bus.cap_valid = 1'b1;
    repeat (300) step();
    bus.cap_valid = 1'b0;
    checks++;
    if (bus.drop_cnt !== 8'd255 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat: got drop=%0d ovf=%b expected 255/1", bus.drop_cnt, bus.overflow);
    end
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.drop_cnt !== 8'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr: got drop=%0d ovf=%b expected 0/0", bus.drop_cnt, bus.overflow);
    end
    bus.clr_ovf = 1'b1;
    push(32'hBAD, 32'hBAD);
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.drop_cnt !== 8'd1 || bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL clr_vs_drop: got drop=%0d ovf=%b count=%0d expected 1/1/8", bus.drop_cnt, bus.overflow, bus.count);
    end
    bus.out_ready = 1'b1;
    repeat (8) step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h800 + 32'(4 * i), 32'(i));
    checks++;
    if (bus.count !== 4'd5) begin
      errors++;
      $display("FAIL arst_pre: got count=%0d expected 5", bus.count);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 4'd0 || bus.out_pc !== 32'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: got valid=%b count=%0d pc=%h ovf=%b expected 0/0/0/0", bus.out_valid, bus.count, bus.out_pc, bus.overflow);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL arst_post: got valid=%b count=%0d expected 0/0", bus.out_valid, bus.count);
    end
  endtask

  initial begin
    bus.trace_en  = 1'b0;
    bus.cap_valid = 1'b0;
    bus.pc_in     = '0;
    bus.res_in    = '0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_trace_en();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
